// File: rtl/fetch_stall_front_pkg.sv
// fetch_stall_front_pkg: shared constants for the fetch/stall front end
package fetch_stall_front_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int DEFAULT_CTRL_W = 10;
    localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/fetch_stall_front_sat_counter.sv
// sat_counter: event counter that sticks at its maximum instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk)
        count <= reset ? '0 : (inc && count != '1) ? count + CNT_W'(1) : count;
endmodule

// File: rtl/fetch_stall_front.sv
// fetch_stall_front: PC, IF/ID and ID/EX control registers driven by stall/flush controls
module fetch_stall_front
    import fetch_stall_front_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int CTRL_W = DEFAULT_CTRL_W,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PC_WriteEnable,
    input  logic              IFID_WriteEnable,
    input  logic              StallFlush,
    input  logic              BranchTaken,
    input  logic [31:0]       BranchTarget,
    input  logic              Jump,
    input  logic [31:0]       JumpTarget,
    input  logic [31:0]       IMem_Instr,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    output logic [31:0]       PC,
    output logic [31:0]       IFID_PCPlus4,
    output logic [31:0]       IFID_Instr,
    output logic              IFID_Valid,
    output logic [CTRL_W-1:0] IDEX_Ctrl,
    output logic              IDEX_Valid,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);
    logic        redir;
    logic [31:0] target;
    logic [31:0] pcPlus4;
    // A redirect while the PC is frozen is dropped; ID reasserts it next cycle.
    always_comb begin
        redir = (BranchTaken | Jump) & PC_WriteEnable;
        target = (BranchTaken ? BranchTarget : JumpTarget) & ~32'h3;
        pcPlus4 = PC + PC_INC;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            PC <= RESET_PC;
            IFID_Instr <= NOP_INSTR;
            IFID_PCPlus4 <= '0;
            IFID_Valid <= 1'b0;
            IDEX_Ctrl <= '0;
            IDEX_Valid <= 1'b0;
        end else begin
            PC <= redir ? target : PC_WriteEnable ? pcPlus4 : PC;
            if (redir) begin
                IFID_Instr <= NOP_INSTR;
                IFID_PCPlus4 <= '0;
                IFID_Valid <= 1'b0;
            end else if (IFID_WriteEnable) begin
                IFID_Instr <= IMem_Instr;
                IFID_PCPlus4 <= pcPlus4;
                IFID_Valid <= 1'b1;
            end
            IDEX_Ctrl <= (StallFlush || !IFID_Valid) ? '0 : ID_Ctrl;
            IDEX_Valid <= !StallFlush && IFID_Valid;
        end
    end
    sat_counter #(.CNT_W(CNT_W)) uStallCnt (.clk(clk), .reset(reset), .inc(StallFlush), .count(StallCount));
    sat_counter #(.CNT_W(CNT_W)) uFlushCnt (.clk(clk), .reset(reset), .inc(redir), .count(FlushCount));
endmodule

// File: tb/tb_fetch_stall_front.sv
// tb_fetch_stall_front: directed plan steps plus random traffic against a behavioural model
module tb_fetch_stall_front;
    localparam int CW = 10;
    localparam int NW = 4;
    localparam int CMAX = (1 << NW) - 1;
    logic clk = 1'b0;
    logic reset;
    logic pcWe, ifWe, stallFlush, branchTaken, jump;
    logic [31:0] branchTarget, jumpTarget, imemInstr;
    logic [CW-1:0] idCtrl;
    logic [31:0] pc, ifPc4, ifInstr;
    logic ifValid, exValid;
    logic [CW-1:0] exCtrl;
    logic [NW-1:0] stallCount, flushCount;
    int checks = 0;
    int errors = 0;
    logic [31:0] mPC, mIfInstr, mIfPc4;
    logic mIfValid, mExValid;
    logic [CW-1:0] mExCtrl;
    int mStall, mFlush;

    fetch_stall_front #(.RESET_PC(32'h0), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .PC_WriteEnable(pcWe), .IFID_WriteEnable(ifWe),
        .StallFlush(stallFlush), .BranchTaken(branchTaken), .BranchTarget(branchTarget),
        .Jump(jump), .JumpTarget(jumpTarget), .IMem_Instr(imemInstr), .ID_Ctrl(idCtrl),
        .PC(pc), .IFID_PCPlus4(ifPc4), .IFID_Instr(ifInstr), .IFID_Valid(ifValid),
        .IDEX_Ctrl(exCtrl), .IDEX_Valid(exValid), .StallCount(stallCount), .FlushCount(flushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Next state from the rules: EX sees the old IF/ID, IF/ID sees the old PC.
    task automatic model();
        bit taken;
        logic [31:0] tgt;
        taken = (branchTaken || jump) && pcWe;
        tgt = branchTaken ? branchTarget : jumpTarget;
        tgt[1:0] = 2'b00;
        if (reset) begin
            mPC = 0; mIfInstr = 0; mIfPc4 = 0; mIfValid = 0;
            mExCtrl = 0; mExValid = 0; mStall = 0; mFlush = 0;
        end else begin
            mExValid = mIfValid && !stallFlush;
            mExCtrl = mExValid ? idCtrl : '0;
            if (taken) begin
                mIfInstr = 0; mIfPc4 = 0; mIfValid = 0;
            end else if (ifWe) begin
                mIfInstr = imemInstr; mIfPc4 = mPC + 4; mIfValid = 1;
            end
            if (taken) mPC = tgt;
            else if (pcWe) mPC = mPC + 4;
            if (stallFlush) mStall = (mStall < CMAX) ? mStall + 1 : CMAX;
            if (taken) mFlush = (mFlush < CMAX) ? mFlush + 1 : CMAX;
        end
    endtask

    task automatic compareAll();
        chk("PC", pc, mPC);
        chk("IFID_Instr", ifInstr, mIfInstr);
        chk("IFID_PCPlus4", ifPc4, mIfPc4);
        chk("IFID_Valid", 32'(ifValid), 32'(mIfValid));
        chk("IDEX_Ctrl", 32'(exCtrl), 32'(mExCtrl));
        chk("IDEX_Valid", 32'(exValid), 32'(mExValid));
        chk("StallCount", 32'(stallCount), 32'(mStall));
        chk("FlushCount", 32'(flushCount), 32'(mFlush));
    endtask

    task automatic cycle();
        @(posedge clk);
        model();
        #1;
        compareAll();
    endtask

    task automatic setIn(input logic pw, input logic iw, input logic sf, input logic bt,
                         input logic [31:0] btg, input logic j, input logic [31:0] jtg);
        pcWe = pw; ifWe = iw; stallFlush = sf; branchTaken = bt;
        branchTarget = btg; jump = j; jumpTarget = jtg;
        imemInstr = $urandom; idCtrl = CW'($urandom);
    endtask

    task automatic randIn();
        setIn(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
              ($urandom % 8) == 0, $urandom, ($urandom % 10) == 0, $urandom);
    endtask

    initial begin
        reset = 1'b1;
        randIn();
        cycle();
        chk("reset_pc", pc, 32'h0);
        chk("reset_valid", 32'({ifValid, exValid}), 32'h0);
        randIn();
        cycle();
        chk("reset_counts", 32'({stallCount, flushCount}), 32'h0);
        reset = 1'b0;
        setIn(1, 1, 0, 0, 0, 0, 0);
        imemInstr = 32'h8C08_0004;
        cycle();
        chk("rel_pc", pc, 32'h4);
        chk("rel_instr", ifInstr, 32'h8C08_0004);
        chk("rel_pc4", ifPc4, 32'h4);
        chk("rel_valid", 32'(ifValid), 32'h1);
        setIn(1, 1, 0, 0, 0, 0, 0);
        cycle();
        setIn(0, 0, 1, 0, 0, 0, 0);
        cycle();
        chk("stall_pc", pc, 32'h8);
        chk("stall_pc4", ifPc4, 32'h8);
        chk("stall_exvalid", 32'(exValid), 32'h0);
        chk("stall_cnt", 32'(stallCount), 32'h1);
        setIn(1, 1, 0, 0, 0, 0, 0);
        cycle();
        chk("post_stall_pc", pc, 32'hC);
        setIn(1, 1, 0, 1, 32'h43, 0, 0);
        cycle();
        chk("br_pc", pc, 32'h40);
        chk("br_flush", 32'({ifValid, ifInstr}), 32'h0);
        chk("br_cnt", 32'(flushCount), 32'h1);
        setIn(1, 1, 0, 0, 0, 0, 0);
        cycle();
        chk("br_bubble", 32'(exValid), 32'h0);
        setIn(0, 0, 0, 1, 32'h80, 0, 0);
        cycle();
        chk("brstall_pc", pc, 32'h44);
        chk("brstall_cnt", 32'(flushCount), 32'h1);
        setIn(1, 1, 0, 1, 32'h80, 0, 0);
        cycle();
        chk("brretry_pc", pc, 32'h80);
        chk("brretry_cnt", 32'(flushCount), 32'h2);
        setIn(1, 1, 0, 1, 32'h100, 1, 32'h200);
        cycle();
        chk("prio_pc", pc, 32'h100);
        setIn(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cycle();
        chk("jmp_pc", pc, 32'hFFFF_FFFC);
        setIn(1, 1, 0, 0, 0, 0, 0);
        cycle();
        chk("wrap_pc", pc, 32'h0);
        for (int i = 0; i < 20; i++) begin
            setIn(1, 1, 1, 0, 0, 0, 0);
            cycle();
        end
        chk("sat_stall", 32'(stallCount), 32'hF);
        setIn(1, 1, 1, 0, 0, 0, 0);
        cycle();
        chk("sat_hold", 32'(stallCount), 32'hF);
        for (int i = 0; i < 400; i++) begin
            randIn();
            reset = ($urandom % 50) == 0;
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
